// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel packing stage.
package pixel_pkg;

  localparam int unsigned BPW    = 4;
  localparam int unsigned WORD_W = 32;

  // One packed output word with its framing markers.
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [BPW-1:0]    keep;
    logic              sof;
    logic              last;
  } pkt_word_t;

  // Contiguous byte enables for a word that closes with its last byte in slot 'lane'.
  function automatic logic [BPW-1:0] keep_mask(input logic [1:0] lane);
    logic [BPW-1:0] mask;
    unique case (lane)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0011;
      2'd2:    mask = 4'b0111;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/pkt_fifo2.sv
// Two-entry synchronous FIFO of packed words; head is the oldest entry.
module pkt_fifo2
  import pixel_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  pkt_word_t  wdata,
  input  logic       pop,
  output logic [1:0] occupancy,
  output pkt_word_t  head
);

  pkt_word_t  mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  // Occupancy bookkeeping; push+pop together leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointers; entries clear on reset so head reads as zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign occupancy = cnt_q;
  assign head      = mem_q[rd_ptr_q];

endmodule

// File: rtl/pixel_packer.sv
// Packs 8-bit pixels little-endian into 32-bit words with frame markers.
module pixel_packer
  import pixel_pkg::*;
#(
  parameter int unsigned IMG_W = 32,
  parameter int unsigned IMG_H = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  pixel_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep,
  output logic        m_sof,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

  logic [1:0]      lane_q, lane_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [23:0]     pack_q, pack_d;
  logic            first_q, first_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;

  logic            accept;
  logic            eol;
  logic            eof;
  logic            close;
  logic [31:0]     word_data;
  pkt_word_t       push_word;
  pkt_word_t       head;
  logic [1:0]      occupancy;
  logic            pop;

  assign ready_out = (occupancy < 2'd2);
  assign accept    = valid_in && ready_out;
  assign eol       = (col_q == ColLast);
  assign eof       = eol && (row_q == RowLast);
  // Lines never share a word, so end of line always closes.
  assign close     = (lane_q == 2'd3) || eol;

  // Merge the incoming pixel into its byte slot; untouched slots stay zero.
  always_comb begin
    word_data = {8'h00, pack_q};
    word_data[{lane_q, 3'b000} +: 8] = pixel_in;
  end

  assign push_word = '{data: word_data, keep: keep_mask(lane_q), sof: first_q, last: eof};

  // Lane, position and pack register advance only on an accepted pixel.
  always_comb begin
    lane_d  = lane_q;
    col_d   = col_q;
    row_d   = row_q;
    pack_d  = pack_q;
    first_d = first_q;
    if (accept) begin
      if (close) begin
        lane_d  = 2'd0;
        pack_d  = '0;
        first_d = eof;
      end else begin
        lane_d = lane_q + 2'd1;
        pack_d = word_data[23:0];
      end
      if (eol) begin
        col_d = '0;
        row_d = eof ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  // Frame accounting counts words carrying the frame end as they leave.
  always_comb begin
    frame_cnt_d = frame_cnt_q + {15'd0, frame_done};
  end

  // Packer state and frame counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_q      <= 2'd0;
      col_q       <= '0;
      row_q       <= '0;
      pack_q      <= '0;
      first_q     <= 1'b1;
      frame_cnt_q <= 16'd0;
    end else begin
      lane_q      <= lane_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pack_q      <= pack_d;
      first_q     <= first_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  pkt_fifo2 u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (accept && close),
    .wdata     (push_word),
    .pop       (pop),
    .occupancy (occupancy),
    .head      (head)
  );

  assign m_valid    = (occupancy != 2'd0);
  assign pop        = m_valid && m_ready;
  assign frame_done = pop && head.last;
  assign m_data     = head.data;
  assign m_keep     = head.keep;
  assign m_sof      = head.sof;
  assign m_last     = head.last;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Randomised and directed bench for pixel_packer against a word-level reference model.
module tb_pixel_packer;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        sof;
    logic        last;
  } wrd_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  pixel_in;
  logic        valid_in;
  logic        m_ready;
  logic [1:0]  sel;

  logic        rdy [3];
  logic [31:0] dat [3];
  logic [3:0]  kp  [3];
  logic        sf  [3];
  logic        ls  [3];
  logic        mv  [3];
  logic        fd  [3];
  logic [15:0] fc  [3];

  logic        ready_out, m_valid, m_sof, m_last, frame_done;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  pixel_packer #(.IMG_W(32), .IMG_H(32)) u_d32 (
    .clk(clk), .rstn(rstn), .pixel_in(pixel_in), .valid_in(valid_in && (sel == 2'd0)),
    .ready_out(rdy[0]), .m_data(dat[0]), .m_keep(kp[0]), .m_sof(sf[0]), .m_last(ls[0]),
    .m_valid(mv[0]), .m_ready(m_ready && (sel == 2'd0)), .frame_done(fd[0]), .frame_cnt(fc[0])
  );

  pixel_packer #(.IMG_W(6), .IMG_H(2)) u_d6 (
    .clk(clk), .rstn(rstn), .pixel_in(pixel_in), .valid_in(valid_in && (sel == 2'd1)),
    .ready_out(rdy[1]), .m_data(dat[1]), .m_keep(kp[1]), .m_sof(sf[1]), .m_last(ls[1]),
    .m_valid(mv[1]), .m_ready(m_ready && (sel == 2'd1)), .frame_done(fd[1]), .frame_cnt(fc[1])
  );

  pixel_packer #(.IMG_W(1), .IMG_H(1)) u_d1 (
    .clk(clk), .rstn(rstn), .pixel_in(pixel_in), .valid_in(valid_in && (sel == 2'd2)),
    .ready_out(rdy[2]), .m_data(dat[2]), .m_keep(kp[2]), .m_sof(sf[2]), .m_last(ls[2]),
    .m_valid(mv[2]), .m_ready(m_ready && (sel == 2'd2)), .frame_done(fd[2]), .frame_cnt(fc[2])
  );

  assign ready_out  = rdy[sel];
  assign m_data     = dat[sel];
  assign m_keep     = kp[sel];
  assign m_sof      = sf[sel];
  assign m_last     = ls[sel];
  assign m_valid    = mv[sel];
  assign frame_done = fd[sel];
  assign frame_cnt  = fc[sel];

  // Reference model state
  int          W, H;
  int          pidx;
  bit          wsof;
  logic [7:0]  bq [$];
  wrd_t        exp_q [$];
  wrd_t        got [$];
  logic [15:0] exp_cnt;
  int          fd_seen;
  int          nxt;
  int          tests = 0;
  int          fails = 0;
  logic        acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, expv);
    end
  endtask

  // Frame-position rules: a word ends at 4 bytes, end of line, or end of frame.
  task automatic model_px(input logic [7:0] px);
    int   col;
    bit   fend;
    wrd_t w;
    col  = pidx % W;
    fend = (pidx == W * H - 1);
    if (bq.size() == 0) wsof = (pidx == 0);
    bq.push_back(px);
    if (bq.size() == 4 || col == W - 1 || fend) begin
      w.data = 32'd0;
      for (int i = 0; i < bq.size(); i++) w.data = w.data | (32'(bq[i]) << (8 * i));
      w.keep = 4'((1 << bq.size()) - 1);
      w.sof  = wsof;
      w.last = fend;
      exp_q.push_back(w);
      bq.delete();
    end
    pidx = fend ? 0 : pidx + 1;
  endtask

  // One clock: check outputs against the model, drive new inputs, advance the model.
  task automatic step(input logic v, input logic [7:0] px, input logic mr, output logic a);
    logic pop;
    wrd_t cur;
    @(negedge clk);
    chk("ready_out", 32'(ready_out), 32'(exp_q.size() < 2));
    chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("m_data", m_data, exp_q[0].data);
      chk("m_keep", 32'(m_keep), 32'(exp_q[0].keep));
      chk("m_sof", 32'(m_sof), 32'(exp_q[0].sof));
      chk("m_last", 32'(m_last), 32'(exp_q[0].last));
    end
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    cur = '{data: m_data, keep: m_keep, sof: m_sof, last: m_last};
    valid_in = v;
    pixel_in = px;
    m_ready  = mr;
    #1;
    a   = v && (exp_q.size() < 2);
    pop = mr && (exp_q.size() != 0);
    chk("frame_done", 32'(frame_done), 32'(pop && exp_q[0].last));
    if (frame_done) fd_seen++;
    if (pop) begin
      got.push_back(cur);
      if (exp_q[0].last) exp_cnt = exp_cnt + 16'd1;
      exp_q.delete(0);
    end
    if (a) model_px(px);
  endtask

  task automatic do_reset(input logic [1:0] s);
    @(negedge clk);
    rstn     = 1'b0;
    valid_in = 1'b0;
    m_ready  = 1'b0;
    sel      = s;
    W = (s == 2'd0) ? 32 : (s == 2'd1) ? 6 : 1;
    H = (s == 2'd0) ? 32 : (s == 2'd1) ? 2 : 1;
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_keep", 32'(m_keep), 32'd0);
    chk("rst_m_sof", 32'(m_sof), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_ready_out", 32'(ready_out), 32'd1);
    exp_q.delete();
    bq.delete();
    got.delete();
    pidx    = 0;
    exp_cnt = 16'd0;
    fd_seen = 0;
    nxt     = 0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, acc);
  endtask

  task automatic chk_word(input string name, input int idx, input logic [31:0] d,
                          input logic [3:0] k, input logic s, input logic l);
    if (got.size() <= idx) begin
      chk({name, "_present"}, 32'(got.size()), 32'(idx + 1));
    end else begin
      chk({name, "_data"}, got[idx].data, d);
      chk({name, "_keep"}, 32'(got[idx].keep), 32'(k));
      chk({name, "_sof"}, 32'(got[idx].sof), 32'(s));
      chk({name, "_last"}, 32'(got[idx].last), 32'(l));
    end
  endtask

  initial begin
    int bad, k, nsof, nlast;
    rstn = 1'b0; valid_in = 1'b0; m_ready = 1'b0; pixel_in = 8'h00; sel = 2'd0;

    // Full frame at 32x32, always ready
    do_reset(2'd0);
    for (int i = 0; i < 1024; i++) step(1'b1, 8'(i), 1'b1, acc);
    drain(4);
    chk("f32_words", 32'(got.size()), 32'd256);
    chk_word("f32_w0", 0, 32'h03020100, 4'hF, 1'b1, 1'b0);
    chk_word("f32_w255", 255, 32'hFFFEFDFC, 4'hF, 1'b0, 1'b1);
    chk("f32_done_pulses", 32'(fd_seen), 32'd1);
    chk("f32_frame_cnt", 32'(frame_cnt), 32'd1);

    // 6x2 frame: partial words at each line end
    do_reset(2'd1);
    for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h10 + i), 1'b1, acc);
    drain(3);
    chk("f6_words", 32'(got.size()), 32'd4);
    chk_word("f6_w0", 0, 32'h13121110, 4'hF, 1'b1, 1'b0);
    chk_word("f6_w1", 1, 32'h00001514, 4'h3, 1'b0, 1'b0);
    chk_word("f6_w2", 2, 32'h19181716, 4'hF, 1'b0, 1'b0);
    chk_word("f6_w3", 3, 32'h00001B1A, 4'h3, 1'b0, 1'b1);

    // Downstream stall: queue fills after 8 pixels, head holds
    do_reset(2'd0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, nxt[7:0], 1'b0, acc);
      if (acc) nxt++;
    end
    chk("stall_accepts", 32'(nxt), 32'd8);
    chk("stall_ready", 32'(ready_out), 32'd0);
    chk("stall_hold", m_data, 32'h03020100);
    for (int i = 0; i < 3000 && nxt < 1024; i++) begin
      step(1'b1, nxt[7:0], 1'b1, acc);
      if (acc) nxt++;
    end
    drain(4);
    chk("stall_words", 32'(got.size()), 32'd256);
    chk("stall_frame_cnt", 32'(frame_cnt), 32'd1);

    // Random valid/ready over three frames
    do_reset(2'd0);
    for (int i = 0; i < 30000 && nxt < 3072; i++) begin
      step(1'($urandom_range(0, 1)), nxt[7:0], 1'($urandom_range(0, 1)), acc);
      if (acc) nxt++;
    end
    chk("rand_budget", 32'(nxt), 32'd3072);
    drain(4);
    bad = 0; k = 0; nsof = 0; nlast = 0;
    for (int w = 0; w < got.size(); w++) begin
      if (got[w].sof) nsof++;
      if (got[w].last) nlast++;
      for (int b = 0; b < 4; b++) begin
        if (got[w].keep[b]) begin
          if (got[w].data[8*b +: 8] !== 8'(k)) bad++;
          k++;
        end
      end
    end
    chk("rand_byte_errors", 32'(bad), 32'd0);
    chk("rand_byte_count", 32'(k), 32'd3072);
    chk("rand_sof_count", 32'(nsof), 32'd3);
    chk("rand_last_count", 32'(nlast), 32'd3);
    chk("rand_frame_cnt", 32'(frame_cnt), 32'd3);

    // Reset in the middle of a line discards the partial word
    do_reset(2'd0);
    for (int i = 0; i < 13; i++) step(1'b1, 8'(i), 1'b1, acc);
    do_reset(2'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b1, acc);
    drain(3);
    chk("midrst_words", 32'(got.size()), 32'd1);
    chk_word("midrst_w0", 0, 32'h03020100, 4'hF, 1'b1, 1'b0);

    // Frame counter wrap at 1x1
    do_reset(2'd2);
    @(negedge clk);
    force u_d1.frame_cnt_q = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    release u_d1.frame_cnt_q;
    step(1'b1, 8'hA5, 1'b0, acc);
    drain(3);
    chk("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("wrap_done_pulses", 32'(fd_seen), 32'd1);
    chk_word("wrap_w0", 0, 32'h000000A5, 4'h1, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
